// File: rtl/data_cache_nway_pkg.sv
// rtl/data_cache_nway_pkg.sv - shared types and constants for the data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL
    } dcache_state_e;

    localparam logic [2:0] AC_SB = 3'b000;
    localparam logic [2:0] AC_SH = 3'b001;
    localparam logic [2:0] AC_SW = 3'b010;

    localparam int STATS_W = 32;

    // Codes other than SB/SH write the whole word.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wd,
        input logic [2:0]  ac,
        input logic [1:0]  boff
    );
        logic [31:0] r;
        r = old_word;
        case (ac)
            AC_SB:   r[{boff, 3'b000} +: 8]        = wd[7:0];
            AC_SH:   r[{boff[1], 4'b0000} +: 16]   = wd[15:0];
            default: r                             = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_cache_nway_if.sv
// rtl/data_cache_nway_if.sv - CPU-side and memory-side signal bundle of the data cache
interface data_cache_nway_if #(
    parameter int XLEN = 32
);
    logic            cpu_req;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] WD;
    logic            WE;
    logic [2:0]      AddressingControl;
    logic [31:0]     cache_dout;
    logic            stall;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [31:0]     mem_wd;
    logic [31:0]     mem_rd;
    logic            mem_ack;

    modport slave (
        input  cpu_req, A, WD, WE, AddressingControl, mem_rd, mem_ack,
        output cache_dout, stall, mem_req, mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_req, A, WD, WE, AddressingControl, mem_rd, mem_ack,
        input  cache_dout, stall, mem_req, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/data_cache_nway_plru_tree.sv
// rtl/data_cache_nway_plru_tree.sv - tree-PLRU victim select and update for 1, 2 or 4 ways
module plru_tree #(
    parameter  int WAYS = 2,
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PW-1:0] bits,
    input  logic [AW-1:0] way,
    output logic [AW-1:0] victim,
    output logic [PW-1:0] next_bits
);

    generate
        if (WAYS == 4) begin : g_four
            // bits[0] picks the pair, bits[1]/bits[2] pick within the left/right pair.
            always_comb begin
                victim    = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
                next_bits = bits;
                next_bits[0] = ~way[1];
                if (way[1]) next_bits[2] = ~way[0];
                else        next_bits[1] = ~way[0];
            end
        end else if (WAYS == 2) begin : g_two
            always_comb begin
                victim    = bits[0];
                next_bits = ~way[0];
            end
        end else begin : g_one
            logic unused_way;
            assign unused_way = ^way;
            always_comb begin
                victim    = '0;
                next_bits = bits;
            end
        end
    endgenerate

endmodule

// File: rtl/data_cache_nway.sv
// rtl/data_cache_nway.sv - N-way write-back write-allocate data cache; DCACHE_STATS_EN adds hit/miss/writeback counters
module data_cache_nway
    import dcache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic rst,
    data_cache_nway_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [STATS_W-1:0] hit_count,
    output logic [STATS_W-1:0] miss_count,
    output logic [STATS_W-1:0] wb_count
`endif
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int SET_BITS = $clog2(SETS);
    localparam int TAG_W    = XLEN - 2 - OFF_BITS - SET_BITS;
    localparam int WIDX_W   = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

    logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [PLRU_W-1:0] plru_q  [SETS];

    dcache_state_e     state_q, state_d;
    logic [WIDX_W-1:0] cnt_q;
    logic [SET_BITS-1:0] miss_set_q;
    logic [TAG_W-1:0]  miss_tag_q;
    logic [WAY_W-1:0]  vic_way_q;
    logic [TAG_W-1:0]  vic_tag_q;

    logic [WIDX_W-1:0]   a_word;
    logic [SET_BITS-1:0] a_set, plru_set;
    logic [TAG_W-1:0]    a_tag;
    logic                hit, hit_acc, miss_acc, is_last, inv_found, vic_dirty;
    logic [WAY_W-1:0]    hit_way, inv_way, vic_way, plru_victim, plru_way;
    logic [PLRU_W-1:0]   plru_next;

    assign a_word = WIDX_W'((bus.A >> 2) & XLEN'(LINE_WORDS - 1));
    assign a_set  = SET_BITS'(bus.A >> (2 + OFF_BITS));
    assign a_tag  = TAG_W'(bus.A >> (2 + OFF_BITS + SET_BITS));

    function automatic logic [XLEN-1:0] word_addr(
        input logic [TAG_W-1:0] t, input logic [SET_BITS-1:0] s, input logic [WIDX_W-1:0] i
    );
        return (XLEN'(t) << (2 + OFF_BITS + SET_BITS)) | (XLEN'(s) << (2 + OFF_BITS)) | (XLEN'(i) << 2);
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[a_set][w] && tag_q[w][a_set] == a_tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[a_set][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign vic_way   = inv_found ? inv_way : plru_victim;
    assign vic_dirty = valid_q[a_set][vic_way] & dirty_q[a_set][vic_way];
    assign hit_acc   = !rst && bus.cpu_req && state_q == ST_IDLE && hit;
    assign miss_acc  = !rst && bus.cpu_req && state_q == ST_IDLE && !hit;
    assign is_last   = (cnt_q == WIDX_W'(LINE_WORDS - 1));

    // In IDLE the tree serves the addressed set; during a refill it serves the miss set.
    assign plru_set = (state_q == ST_IDLE) ? a_set : miss_set_q;
    assign plru_way = (state_q == ST_IDLE) ? hit_way : vic_way_q;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits      (plru_q[plru_set]),
        .way       (plru_way),
        .victim    (plru_victim),
        .next_bits (plru_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.cache_dout = '0;
        bus.stall      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        if (!rst) begin
            if (hit_acc) bus.cache_dout = data_q[hit_way][a_set][a_word];
            bus.stall = miss_acc || (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (miss_acc) state_d = vic_dirty ? ST_WRITEBACK : ST_REFILL;
                end
                ST_WRITEBACK: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.mem_addr = word_addr(vic_tag_q, miss_set_q, cnt_q);
                    bus.mem_wd   = data_q[vic_way_q][miss_set_q][cnt_q];
                    if (bus.mem_ack && is_last) state_d = ST_REFILL;
                end
                ST_REFILL: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = word_addr(miss_tag_q, miss_set_q, cnt_q);
                    if (bus.mem_ack && is_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            cnt_q      <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
            vic_way_q  <= '0;
            vic_tag_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_acc) begin
                        plru_q[a_set] <= plru_next;
                        if (bus.WE) begin
                            data_q[hit_way][a_set][a_word] <= store_merge(
                                data_q[hit_way][a_set][a_word], bus.WD[31:0],
                                bus.AddressingControl, bus.A[1:0]);
                            dirty_q[a_set][hit_way] <= 1'b1;
                        end
                    end
                    if (miss_acc) begin
                        miss_set_q <= a_set;
                        miss_tag_q <= a_tag;
                        vic_way_q  <= vic_way;
                        vic_tag_q  <= tag_q[vic_way][a_set];
                        cnt_q      <= '0;
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ack) cnt_q <= is_last ? '0 : cnt_q + 1'b1;
                end
                ST_REFILL: begin
                    if (bus.mem_ack) begin
                        data_q[vic_way_q][miss_set_q][cnt_q] <= bus.mem_rd;
                        cnt_q <= is_last ? '0 : cnt_q + 1'b1;
                        if (is_last) begin
                            tag_q[vic_way_q][miss_set_q]   <= miss_tag_q;
                            valid_q[miss_set_q][vic_way_q] <= 1'b1;
                            dirty_q[miss_set_q][vic_way_q] <= 1'b0;
                            plru_q[miss_set_q]             <= plru_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that completes a refilled access belongs to that miss, not to a new hit.
    logic replay_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
            replay_q   <= 1'b0;
        end else begin
            replay_q <= (state_q == ST_REFILL) && bus.mem_ack && is_last;
            if (hit_acc && !replay_q) hit_count <= hit_count + 1'b1;
            if (miss_acc) miss_count <= miss_count + 1'b1;
            if (state_q == ST_WRITEBACK && bus.mem_ack && is_last) wb_count <= wb_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_nway.sv
// tb/tb_data_cache_nway.sv - self-checking bench for data_cache_nway against a line-level LRU model
module tb_data_cache_nway;
    import dcache_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    data_cache_nway_if #(.XLEN(32)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    data_cache_nway #(.XLEN(32), .SETS(64), .WAYS(2), .LINE_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Backing memory: untouched words hold an address-derived pattern.
    logic [31:0] backing [int unsigned];
    function automatic logic [31:0] backing_rd(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } xact_t;
    xact_t log_q[$];

    int          ack_delay;
    bit          ack_noise;
    int          wait_cnt;
    logic [31:0] hold_addr, hold_wd;

    always @(negedge clk) begin
        if (!bus.mem_req) begin
            bus.mem_ack = ack_noise ? 1'($urandom) : 1'b0;
            bus.mem_rd  = $urandom;
            wait_cnt    = 0;
        end else begin
            if (wait_cnt == 0) begin
                hold_addr = bus.mem_addr;
                hold_wd   = bus.mem_wd;
            end else begin
                check("wait_addr_stable", bus.mem_addr, hold_addr);
                check("wait_wd_stable", bus.mem_wd, hold_wd);
            end
            if (wait_cnt < ack_delay) begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end else begin
                bus.mem_ack = 1'b1;
                wait_cnt    = 0;
                if (bus.mem_we) backing[bus.mem_addr] = bus.mem_wd;
                else            bus.mem_rd = backing_rd(bus.mem_addr);
                log_q.push_back('{we: bus.mem_we, addr: bus.mem_addr, wd: bus.mem_we ? bus.mem_wd : 32'h0});
            end
        end
    end

    // Reference model: two ways per set, true LRU (what a 2-way PLRU reduces to).
    logic [31:0] mdata [2][64][4];
    logic [31:0] mtag  [2][64];
    bit          mvalid[2][64];
    bit          mdirty[2][64];
    int          mlast [64];
    int          m_hit, m_miss, m_wb;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                mvalid[w][s] = 0;
                mdirty[w][s] = 0;
            end
            mlast[s] = 1;
        end
        m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] ac, input logic [31:0] a);
        int sh;
        logic [31:0] mask;
        if (ac == 3'b000) begin
            sh = 8 * (a % 4);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end
        if (ac == 3'b001) begin
            sh = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic do_access(input logic [31:0] a, input bit we, input logic [2:0] ac,
                             input logic [31:0] wd, input int delay, output logic [31:0] dout_obs);
        int set, word, way, v, n, exp_stall;
        logic [31:0] tag, base, exp_dout;
        xact_t exp_q[$];
        set  = (a / 16) % 64;
        word = (a / 4) % 4;
        tag  = a / 1024;
        way  = -1;
        exp_stall = 0;
        for (int w = 0; w < 2; w++) if (mvalid[w][set] && mtag[w][set] == tag && way < 0) way = w;
        if (way < 0) begin
            m_miss++;
            if (!mvalid[0][set])      v = 0;
            else if (!mvalid[1][set]) v = 1;
            else                      v = 1 - mlast[set];
            if (mvalid[v][set] && mdirty[v][set]) begin
                m_wb++;
                for (int i = 0; i < 4; i++)
                    exp_q.push_back('{we: 1'b1, addr: mtag[v][set] * 1024 + set * 16 + i * 4, wd: mdata[v][set][i]});
                exp_stall += 4 * (delay + 1);
            end
            base = a - (a % 16);
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{we: 1'b0, addr: base + i * 4, wd: 32'h0});
                mdata[v][set][i] = backing_rd(base + i * 4);
            end
            exp_stall += 4 * (delay + 1) + 1;
            mvalid[v][set] = 1;
            mdirty[v][set] = 0;
            mtag[v][set]   = tag;
            way = v;
        end else begin
            m_hit++;
        end
        exp_dout = mdata[way][set][word];
        if (we) begin
            mdata[way][set][word] = model_store(exp_dout, wd, ac, a);
            mdirty[way][set] = 1;
        end
        mlast[set] = way;

        ack_delay = delay;
        bus.A = a; bus.WE = we; bus.AddressingControl = ac; bus.WD = wd; bus.cpu_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.stall && n < 400) begin
            n++;
            @(negedge clk);
        end
        dout_obs = bus.cache_dout;
        check("dout", bus.cache_dout, exp_dout);
        check("stall_cycles", n, exp_stall);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        bus.WE = 1'b0;
        check("xact_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("xact_we", log_q[i].we, exp_q[i].we);
            check("xact_addr", log_q[i].addr, exp_q[i].addr);
            check("xact_wd", log_q[i].wd, exp_q[i].wd);
        end
        log_q.delete();
        @(negedge clk);
        check("idle_stall", bus.stall, 1'b0);
        check("idle_mem_req", bus.mem_req, 1'b0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;
    bit          found;
    int          n;
    int          setv;
    logic [31:0] ra;

    initial begin
        checks = 0; failures = 0;
        ack_delay = 0; ack_noise = 0; wait_cnt = 0;
        bus.mem_ack = 1'b0; bus.mem_rd = '0;
        bus.cpu_req = 1'b1; bus.A = 32'h100; bus.WD = '0; bus.WE = 1'b0; bus.AddressingControl = AC_SW;
        backing[32'h100] = 32'h11223344;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        check("rst_dout", bus.cache_dout, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        model_reset();

        do_access(32'h100, 0, AC_SW, 32'h0, 0, d);
        check("first_fill_word0", d, 32'h11223344);
        do_access(32'h101, 1, AC_SB, 32'h000000AB, 0, d);
        do_access(32'h100, 0, AC_SW, 32'h0, 0, d);
        check("sb_merge", d, 32'h1122AB44);

        ack_noise = 1;
        do_access(32'h500, 0, AC_SW, 32'h0, 0, d);
        do_access(32'h900, 0, AC_SW, 32'h0, 0, d);
        check("wb_word0_mem", backing_rd(32'h100), 32'h1122AB44);
        do_access(32'h504, 0, AC_SW, 32'h0, 0, d);

        do_access(32'hA00, 0, AC_SW, 32'h0, 3, d);
        do_access(32'hA06, 1, AC_SH, 32'hCAFEBEEF, 3, d);
        do_access(32'hE00, 0, AC_SW, 32'h0, 3, d);
        do_access(32'h1200, 1, AC_SW, 32'h12345678, 3, d);

        ack_delay = 0;
        bus.A = 32'h2040; bus.WE = 1'b0; bus.cpu_req = 1'b1;
        found = 0; n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            found = bus.mem_req && bus.mem_addr == 32'h2048;
        end
        check("refill_word2_seen", 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_mem_req_now", bus.mem_req, 1'b0);
        @(posedge clk);
        #1;
        check("abort_mem_req_next", bus.mem_req, 1'b0);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("abort_idle_mem_req", bus.mem_req, 1'b0);
        @(posedge clk);
        #1;
        log_q.delete();
        model_reset();
        do_access(32'h2040, 0, AC_SW, 32'h0, 0, d);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 2))
                0:       setv = 16;
                1:       setv = 3;
                default: setv = 40;
            endcase
            ra = $urandom_range(0, 3) * 1024 + setv * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
            do_access(ra, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom,
                      int'($urandom_range(0, 2)), d);
        end

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, m_hit);
        check("miss_count", miss_count, m_miss);
        check("wb_count", wb_count, m_wb);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
